// File: rtl/eda_loader_pkg.sv
// Shared types and helpers for the pixel loader.
package eda_loader_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SETTLE    = 3'd2,
    START     = 3'd3,
    WAIT_DONE = 3'd4
  } loader_state_e;

  // Width of a counter that must be able to hold the value max_count.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/eda_raster_counter.sv
// Raster-order row/column counter. clr_i forces (0,0); clr_i together with
// inc_i yields the position after (0,0), which is how a restarted frame
// continues after its first pixel has been written to address 0.
module eda_raster_counter #(
  parameter int M       = 4,
  parameter int N       = 4,
  parameter int I_WIDTH = 2,
  parameter int J_WIDTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [I_WIDTH-1:0] i_o,
  output logic [J_WIDTH-1:0] j_o,
  output logic               last_o
);

  localparam logic [I_WIDTH-1:0] I_LAST = I_WIDTH'(M - 1);
  localparam logic [J_WIDTH-1:0] J_LAST = J_WIDTH'(N - 1);

  logic [I_WIDTH-1:0] i_q, i_d, base_i;
  logic [J_WIDTH-1:0] j_q, j_d, base_j;

  // Next position: start from (0,0) when cleared, then step with wrap.
  always_comb begin
    base_i = clr_i ? '0 : i_q;
    base_j = clr_i ? '0 : j_q;
    i_d    = base_i;
    j_d    = base_j;
    if (inc_i) begin
      if (base_j == J_LAST) begin
        j_d = '0;
        i_d = (base_i == I_LAST) ? '0 : base_i + 1'b1;
      end else begin
        j_d = base_j + 1'b1;
      end
    end
  end

  // Position register.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_q <= '0;
      j_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

  assign i_o    = i_q;
  assign j_o    = j_q;
  assign last_o = (i_q == I_LAST) && (j_q == J_LAST);

endmodule

// File: rtl/eda_pixel_loader.sv
// Streams one raster-order frame into the regional-max core's image RAM,
// pulses start once the frame is written and settled, then blocks the
// stream until the core reports done.
// Optional macro EDA_LOADER_TIMEOUT_EN adds TIMEOUT_CYCLES and a timeout
// output that abandons WAIT_DONE when done never rises.
module eda_pixel_loader
  import eda_loader_pkg::*;
#(
  parameter int M             = 4,
  parameter int N             = 4,
  parameter int PIXEL_WIDTH   = 8,
  parameter int I_WIDTH       = 2,
  parameter int J_WIDTH       = 2,
  parameter int ADDR_WIDTH    = I_WIDTH + J_WIDTH,
  parameter int SETTLE_CYCLES = 3
`ifdef EDA_LOADER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [PIXEL_WIDTH-1:0] s_pixel,
  input  logic                   s_sof,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [PIXEL_WIDTH-1:0] pixel_out,
  output logic                   write_en,
  output logic                   start,
  input  logic                   done,
  output logic                   busy,
  output logic                   sof_err
`ifdef EDA_LOADER_TIMEOUT_EN
  , output logic                 timeout
`endif
);

  localparam int SW = cnt_width(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES);
  localparam bit SINGLE_PIXEL = (M * N == 1);

  loader_state_e          state_q, state_d;
  logic                   s_ready_q, s_ready_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [PIXEL_WIDTH-1:0] pixel_q, pixel_d;
  logic                   sof_err_q, sof_err_d;
  logic [SW-1:0]          settle_q, settle_d;
  logic                   done_q;
  logic                   cnt_clr, cnt_inc, cnt_last;
  logic [I_WIDTH-1:0]     cnt_i;
  logic [J_WIDTH-1:0]     cnt_j;
  logic                   transfer, done_rise;

`ifdef EDA_LOADER_TIMEOUT_EN
  localparam int TW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          timeout_q, timeout_d;
`endif

  assign transfer  = s_valid & s_ready_q;
  assign done_rise = done & ~done_q;

  eda_raster_counter #(
    .M       (M),
    .N       (N),
    .I_WIDTH (I_WIDTH),
    .J_WIDTH (J_WIDTH)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .i_o    (cnt_i),
    .j_o    (cnt_j),
    .last_o (cnt_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, write-path next values and the start strobe.
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    pixel_d   = pixel_q;
    sof_err_d = 1'b0;
    settle_d  = '0;
`ifdef EDA_LOADER_TIMEOUT_EN
    tmo_d     = '0;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (transfer) begin
          if (s_sof) begin
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            pixel_d   = s_pixel;
            cnt_clr   = 1'b1;
            cnt_inc   = 1'b1;
            state_d   = SINGLE_PIXEL ? SETTLE : LOAD;
          end else begin
            sof_err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (transfer) begin
          wr_en_d = 1'b1;
          pixel_d = s_pixel;
          cnt_inc = 1'b1;
          if (s_sof) begin
            // Restart the frame: this pixel becomes (0,0).
            sof_err_d = 1'b1;
            wr_addr_d = '0;
            cnt_clr   = 1'b1;
          end else begin
            wr_addr_d = ADDR_WIDTH'({cnt_i, cnt_j});
            if (cnt_last) state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        // Entry cycle carries the final write; SETTLE_CYCLES idle cycles follow.
        if (settle_q == SETTLE_LAST) begin
          state_d = START;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      START: begin
        start   = 1'b1;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_rise) begin
          state_d = IDLE;
        end
`ifdef EDA_LOADER_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    s_ready_d = (state_d == IDLE) || (state_d == LOAD);
  end

  // Registered write port, handshake ready, framing-error pulse and done edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_ready_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      pixel_q   <= '0;
      sof_err_q <= 1'b0;
      settle_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      s_ready_q <= s_ready_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      pixel_q   <= pixel_d;
      sof_err_q <= sof_err_d;
      settle_q  <= settle_d;
      done_q    <= done;
    end
  end

`ifdef EDA_LOADER_TIMEOUT_EN
  // Done-wait watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`endif

  assign s_ready   = s_ready_q;
  assign write_en  = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign pixel_out = pixel_q;
  assign sof_err   = sof_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_eda_pixel_loader.sv
// Scoreboard bench for eda_pixel_loader: stimulus pushes expected writes,
// framing errors and start edges; a negedge monitor pops and compares.
module tb_eda_pixel_loader;

  localparam int M = 4;
  localparam int N = 4;
  localparam int PW = 8;
  localparam int IW = 2;
  localparam int JW = 2;
  localparam int AW = IW + JW;
  localparam int MN = M * N;
  localparam int SETTLE = 3;
  localparam int unsigned NEVER = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [PW-1:0] s_pixel = '0;
  logic          s_sof = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] pixel_out;
  logic          write_en;
  logic          start;
  logic          done = 1'b0;
  logic          busy;
  logic          sof_err;
`ifdef EDA_LOADER_TIMEOUT_EN
  logic          timeout;
`endif

  eda_pixel_loader dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_pixel   (s_pixel),
    .s_sof     (s_sof),
    .wr_addr   (wr_addr),
    .pixel_out (pixel_out),
    .write_en  (write_en),
    .start     (start),
    .done      (done),
    .busy      (busy),
    .sof_err   (sof_err)
`ifdef EDA_LOADER_TIMEOUT_EN
    , .timeout (timeout)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int unsigned   e;
    logic [AW-1:0] addr;
    logic [PW-1:0] pix;
  } wr_t;

  wr_t         wq[$];
  int unsigned eq[$];
  int unsigned sq[$];

  bit          in_frame = 1'b0;
  int          idx = 0;
  int unsigned last_edge = 0;
  int unsigned done_edge = 0;
  bit          mon_en = 1'b0;
  bit          spur_req = 1'b0;
  int          cd = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: frame position as a plain pixel index.
  task automatic model_transfer(input logic [PW-1:0] pix, input bit sof, input int unsigned e);
    wr_t w;
    w.e = e;
    w.pix = pix;
    if (!in_frame) begin
      if (sof) begin
        w.addr = '0;
        wq.push_back(w);
        in_frame = 1'b1;
        idx = 1;
      end else begin
        eq.push_back(e);
      end
    end else if (sof) begin
      eq.push_back(e);
      w.addr = '0;
      wq.push_back(w);
      idx = 1;
    end else begin
      w.addr = AW'(((idx / N) << JW) | (idx % N));
      wq.push_back(w);
      idx++;
    end
    if (in_frame && idx == MN) begin
      in_frame = 1'b0;
      idx = 0;
      last_edge = e;
      done_edge = NEVER;
      sq.push_back(e + SETTLE + 1);
    end
  endtask

  // Present one pixel; optional random bubbles before it goes valid.
  task automatic send(input logic [PW-1:0] pix, input bit sof, input int gap_pct);
    bit sent = 1'b0;
    bit first = 1'b1;
    int waited = 0;
    while (!sent) begin
      @(negedge clk);
      if (first || !s_valid) s_valid = ($urandom_range(0, 99) >= gap_pct);
      first = 1'b0;
      if (s_valid) begin
        s_pixel = pix;
        s_sof = sof;
      end else begin
        s_pixel = PW'($urandom);
        s_sof = 1'($urandom);
      end
      if (s_valid && s_ready) begin
        model_transfer(pix, sof, cyc + 1);
        sent = 1'b1;
      end
      waited++;
      if (!sent && waited > 300) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: got s_ready=0 for 300 cycles required a handshake");
        sent = 1'b1;
      end
    end
  endtask

  task automatic bus_idle();
    @(negedge clk);
    s_valid = 1'b0;
    s_sof = 1'b0;
  endtask

  task automatic frame(input int gap_pct, input logic [PW-1:0] base, input bit rnd);
    for (int p = 0; p < MN; p++) begin
      send(rnd ? PW'($urandom) : PW'(base + p), p == 0, gap_pct);
    end
  endtask

  // Core stand-in: answer each start with a done pulse a few cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        done = 1'b0;
      end else if (spur_req) begin
        done = 1'b1;
        spur_req = 1'b0;
      end else if (start) begin
        cd = $urandom_range(1, 5);
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          done = 1'b1;
          done_edge = cyc + 1;
        end
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (write_en) begin
        if (wq.size() == 0) begin
          check("unexpected_write", 32'(write_en), 32'd0);
        end else begin
          wr_t w;
          w = wq.pop_front();
          check("write_cycle", cyc, w.e);
          check("wr_addr", 32'(wr_addr), 32'(w.addr));
          check("pixel_out", 32'(pixel_out), 32'(w.pix));
          $display("write addr=%0d pixel=%02h cycle=%0d", wr_addr, pixel_out, cyc);
        end
      end
      if (sof_err) begin
        if (eq.size() == 0) check("unexpected_sof_err", 32'(sof_err), 32'd0);
        else check("sof_err_cycle", cyc, eq.pop_front());
      end
      if (start) begin
        if (sq.size() == 0) check("unexpected_start", 32'(start), 32'd0);
        else check("start_cycle", cyc, sq.pop_front());
        $display("start cycle=%0d", cyc);
      end
      if (cyc >= last_edge && cyc < done_edge) begin
        check("ready_low_while_busy", 32'(s_ready), 32'd0);
        check("busy_while_pending", 32'(busy), 32'd1);
      end
      if (last_edge != 0 && cyc == done_edge) begin
        check("ready_after_done", 32'(s_ready), 32'd1);
        check("idle_after_done", 32'(busy), 32'd0);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_write_en", 32'(write_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_pixel_out", 32'(pixel_out), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sof_err", 32'(sof_err), 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(s_ready), 32'd1);

    // Back-to-back frame, valid held high.
    frame(0, 8'h00, 1'b0);
    // Same frame with random bubbles.
    frame(40, 8'h00, 1'b0);
    // Non-sof pixel while idle, then a good frame.
    send(8'hAA, 1'b0, 0);
    frame(20, 8'h00, 1'b1);
    // Frame restarted by sof at pixel 7.
    for (int p = 0; p < 7; p++) send(PW'(8'h40 + p), p == 0, 10);
    frame(10, 8'h80, 1'b0);
    // Spurious done during LOAD must be ignored.
    for (int p = 0; p < MN; p++) begin
      if (p == 5) spur_req = 1'b1;
      send(PW'(8'hC0 + p), p == 0, 0);
    end
    // Reset after 9 pixels of a frame, then a clean frame.
    for (int p = 0; p < 9; p++) send(PW'(8'h20 + p), p == 0, 15);
    @(negedge clk);
    s_valid = 1'b0;
    reset = 1'b1;
    in_frame = 1'b0;
    idx = 0;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_s_ready", 32'(s_ready), 32'd0);
    check("midrst_write_en", 32'(write_en), 32'd0);
    check("midrst_start", 32'(start), 32'd0);
    frame(0, 8'h60, 1'b0);
    // Random frames.
    for (int f = 0; f < 4; f++) frame(30, 8'h00, 1'b1);
    bus_idle();

    for (int k = 0; k < 200 && !(sq.size() == 0 && done_edge != NEVER && cyc > done_edge + 1); k++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    check("writes_outstanding", 32'(wq.size()), 32'd0);
    check("sof_err_outstanding", 32'(eq.size()), 32'd0);
    check("starts_outstanding", 32'(sq.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
